// File: rtl/tournament_br_predictor.sv
// Tournament branch predictor: gshare global PHT, two-level local predictor and
// a choice table, with saturating branch/mispredict statistics for counter readout.
module tournament_br_predictor #(
    parameter int GHR_BITS    = 8,
    parameter int LHT_LOG2    = 6,
    parameter int LHIST_BITS  = 6,
    parameter int CHOICE_LOG2 = 8,
    parameter int CTR_BITS    = 2,
    parameter int MODE        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_pc,
    input  logic        wb_valid,
    input  logic [15:0] wb_pcplus2,
    input  logic        actual_taken,
    input  logic        stat_clear,
    output logic        pred_taken,
    output logic        gl_pred_taken,
    output logic        lc_pred_taken,
    output logic        pred_select,
    output logic [15:0] branch_count,
    output logic [15:0] mispredict_count
);

    localparam int GPHT_N = 1 << GHR_BITS;
    localparam int LPHT_N = 1 << LHIST_BITS;
    localparam int LHT_N  = 1 << LHT_LOG2;
    localparam int CHC_N  = 1 << CHOICE_LOG2;

    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};

    logic [GHR_BITS-1:0]   ghr;
    logic [CTR_BITS-1:0]   gpht [GPHT_N];
    logic [CTR_BITS-1:0]   lpht [LPHT_N];
    logic [CTR_BITS-1:0]   chc  [CHC_N];
    logic [LHIST_BITS-1:0] lht  [LHT_N];

    function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c,
                                                     input logic up);
        if (up)
            return (c == CTR_MAX) ? c : c + CTR_ONE;
        return (c == '0) ? c : c - CTR_ONE;
    endfunction

    function automatic logic mode_pred(input logic gl, input logic lc, input logic sel);
        case (MODE)
            0:       return sel ? gl : lc;
            1:       return gl;
            2:       return lc;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic mode_select(input logic sel);
        case (MODE)
            1:       return 1'b1;
            2:       return 1'b0;
            default: return sel;
        endcase
    endfunction

    // Fetch-side lookup: purely combinational on registered tables.
    logic [GHR_BITS-1:0]    f_gidx;
    logic [LHT_LOG2-1:0]    f_hidx;
    logic [LHIST_BITS-1:0]  f_lidx;
    logic [CHOICE_LOG2-1:0] f_cidx;
    logic                   f_sel;

    assign f_gidx        = ghr ^ if_pc[GHR_BITS:1];
    assign f_hidx        = if_pc[LHT_LOG2:1];
    assign f_lidx        = lht[f_hidx];
    assign f_cidx        = if_pc[CHOICE_LOG2:1];
    assign f_sel         = chc[f_cidx][CTR_BITS-1];
    assign gl_pred_taken = gpht[f_gidx][CTR_BITS-1];
    assign lc_pred_taken = lpht[f_lidx][CTR_BITS-1];
    assign pred_select   = mode_select(f_sel);
    assign pred_taken    = mode_pred(gl_pred_taken, lc_pred_taken, f_sel);

    // wb_valid qualifies every WB input for that cycle: no ready, no back-pressure;
    // when it is low the WB address and direction are ignored entirely.
    logic [15:0]            wb_b;
    logic [GHR_BITS-1:0]    u_gidx;
    logic [LHT_LOG2-1:0]    u_hidx;
    logic [LHIST_BITS-1:0]  u_lidx;
    logic [CHOICE_LOG2-1:0] u_cidx;
    logic                   u_gl, u_lc, u_sel, u_mis;
    logic [CTR_BITS-1:0]    g_next, l_next, c_next;

    assign wb_b   = wb_pcplus2 - 16'd2;
    assign u_gidx = ghr ^ wb_b[GHR_BITS:1];
    assign u_hidx = wb_b[LHT_LOG2:1];
    assign u_lidx = lht[u_hidx];
    assign u_cidx = wb_b[CHOICE_LOG2:1];
    assign u_gl   = gpht[u_gidx][CTR_BITS-1];
    assign u_lc   = lpht[u_lidx][CTR_BITS-1];
    assign u_sel  = chc[u_cidx][CTR_BITS-1];
    assign u_mis  = mode_pred(u_gl, u_lc, u_sel) != actual_taken;
    assign g_next = sat_step(gpht[u_gidx], actual_taken);
    assign l_next = sat_step(lpht[u_lidx], actual_taken);

    always_comb begin
        c_next = chc[u_cidx];
        if (u_gl == actual_taken && u_lc != actual_taken)
            c_next = sat_step(chc[u_cidx], 1'b1);
        else if (u_lc == actual_taken && u_gl != actual_taken)
            c_next = sat_step(chc[u_cidx], 1'b0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GPHT_N; i++) gpht[i] <= CTR_INIT;
        end else if (wb_valid) begin
            gpht[u_gidx] <= g_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LPHT_N; i++) lpht[i] <= CTR_INIT;
        end else if (wb_valid) begin
            lpht[u_lidx] <= l_next;
        end
    end

    // The choice table only trains when both components compete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHC_N; i++) chc[i] <= CTR_INIT;
        end else if (wb_valid && MODE == 0) begin
            chc[u_cidx] <= c_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
            for (int i = 0; i < LHT_N; i++) lht[i] <= '0;
        end else if (wb_valid) begin
            ghr         <= {ghr[GHR_BITS-2:0], actual_taken};
            lht[u_hidx] <= {u_lidx[LHIST_BITS-2:0], actual_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (stat_clear) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (wb_valid) begin
            if (branch_count != 16'hFFFF)
                branch_count <= branch_count + 16'd1;
            if (u_mis && mispredict_count != 16'hFFFF)
                mispredict_count <= mispredict_count + 16'd1;
        end
    end

    // Low PC bits beyond the index ranges are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{if_pc, wb_b};

endmodule

// File: tb/tb_tournament_br_predictor.sv
// Bench for tournament_br_predictor: one instance per MODE driven in lockstep,
// checked against an integer-arithmetic model plus fixed vectors and sequences.
module tb_tournament_br_predictor;

    localparam int HALF = 2;
    localparam int CMAX = 3;

    logic        clk;
    logic        rst;
    logic [15:0] if_pc;
    logic        wb_valid;
    logic [15:0] wb_pcplus2;
    logic        actual_taken;
    logic        stat_clear;
    logic [3:0]  pt, gp, lp, ps;
    logic [15:0] bcnt [4];
    logic [15:0] mcnt [4];

    int checks = 0;
    int errors = 0;

    genvar m;
    generate
        for (m = 0; m < 4; m++) begin : g_dut
            tournament_br_predictor #(
                .GHR_BITS(8), .LHT_LOG2(6), .LHIST_BITS(6),
                .CHOICE_LOG2(8), .CTR_BITS(2), .MODE(m)
            ) dut (
                .clk(clk), .rst(rst), .if_pc(if_pc), .wb_valid(wb_valid),
                .wb_pcplus2(wb_pcplus2), .actual_taken(actual_taken),
                .stat_clear(stat_clear), .pred_taken(pt[m]),
                .gl_pred_taken(gp[m]), .lc_pred_taken(lp[m]),
                .pred_select(ps[m]), .branch_count(bcnt[m]),
                .mispredict_count(mcnt[m])
            );
        end
    endgenerate

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: plain integer tables
    int gpht [256];
    int lpht [64];
    int lht  [64];
    int chc  [256];
    int ghr;
    int bc [4];
    int mc [4];

    function automatic bit m_gl(int pc);
        return gpht[ghr ^ ((pc / 2) % 256)] >= HALF;
    endfunction

    function automatic bit m_lc(int pc);
        return lpht[lht[(pc / 2) % 64]] >= HALF;
    endfunction

    function automatic bit m_chose_global(int pc);
        return chc[(pc / 2) % 256] >= HALF;
    endfunction

    function automatic bit m_pred(int mode, int pc);
        case (mode)
            0: return m_chose_global(pc) ? m_gl(pc) : m_lc(pc);
            1: return m_gl(pc);
            2: return m_lc(pc);
            default: return 1'b0;
        endcase
    endfunction

    // The choice table only learns in tournament mode; in mode 3 it stays weakly-local.
    function automatic bit m_psel(int mode, int pc);
        case (mode)
            0: return m_chose_global(pc);
            1: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int bump(int c, bit up);
        if (up) return (c < CMAX) ? c + 1 : c;
        return (c > 0) ? c - 1 : c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin gpht[i] = HALF - 1; chc[i] = HALF - 1; end
        for (int i = 0; i < 64; i++)  begin lpht[i] = HALF - 1; lht[i] = 0; end
        ghr = 0;
        for (int k = 0; k < 4; k++) begin bc[k] = 0; mc[k] = 0; end
    endtask

    task automatic model_commit(input bit v, input int pc2, input bit t, input bit clr);
        int  b, h, li, gi, ci;
        bit  g, l;
        bit  mis [4];
        if (v) begin
            b  = (pc2 - 2 + 65536) % 65536;
            g  = m_gl(b);
            l  = m_lc(b);
            gi = ghr ^ ((b / 2) % 256);
            h  = (b / 2) % 64;
            li = lht[h];
            ci = (b / 2) % 256;
            for (int k = 0; k < 4; k++) mis[k] = (m_pred(k, b) != t);
            gpht[gi] = bump(gpht[gi], t);
            lpht[li] = bump(lpht[li], t);
            if (g == t && l != t)      chc[ci] = bump(chc[ci], 1'b1);
            else if (l == t && g != t) chc[ci] = bump(chc[ci], 1'b0);
            ghr    = (ghr * 2 + int'(t)) % 256;
            lht[h] = (lht[h] * 2 + int'(t)) % 64;
        end
        for (int k = 0; k < 4; k++) begin
            if (clr) begin
                bc[k] = 0;
                mc[k] = 0;
            end else if (v) begin
                if (bc[k] < 65535) bc[k]++;
                if (mis[k] && mc[k] < 65535) mc[k]++;
            end
        end
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        int pc;
        pc = int'(if_pc);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("m%0d pred pc=%h", k, if_pc), 32'(pt[k]), 32'(m_pred(k, pc)));
            chk($sformatf("m%0d gl pc=%h", k, if_pc), 32'(gp[k]), 32'(m_gl(pc)));
            chk($sformatf("m%0d lc pc=%h", k, if_pc), 32'(lp[k]), 32'(m_lc(pc)));
            chk($sformatf("m%0d sel pc=%h", k, if_pc), 32'(ps[k]), 32'(m_psel(k, pc)));
            chk($sformatf("m%0d branch_count", k), 32'(bcnt[k]), 32'(bc[k]));
            chk($sformatf("m%0d mispredict_count", k), 32'(mcnt[k]), 32'(mc[k]));
        end
    endtask

    // drivers
    task automatic cycle_begin(input logic [15:0] pc, input logic v, input logic [15:0] pc2,
                               input logic t, input logic c, input bit do_chk);
        if_pc        = pc;
        wb_valid     = v;
        wb_pcplus2   = pc2;
        actual_taken = t;
        stat_clear   = c;
        @(negedge clk);
        if (do_chk) check_model();
    endtask

    task automatic cycle_end();
        model_commit(wb_valid, int'(wb_pcplus2), actual_taken, stat_clear);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        wb_valid   = 1'b0;
        stat_clear = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] if_pc;
        logic        v;
        logic [15:0] pc2;
        logic        t;
        logic        clr;
        logic        e_lc;
        logic        e_gl;
        logic        e_pred0;
        logic [15:0] e_bc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // 7 taken updates at 0x3000: local PHT entries 0,1,3..63 each reach 2 in turn;
        // entry 63 flips on the 7th edge, so lc shows 0 in that cycle and 1 after it.
        for (int i = 0; i < 7; i++)
            vecs[i] = '{16'h3000, 1'b1, 16'h3002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'(i)};
        vecs[7] = '{16'h3000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd7};

        if_pc = '0; wb_valid = 1'b0; wb_pcplus2 = '0; actual_taken = 1'b0; stat_clear = 1'b0;
        do_reset();

        // reset state sweep
        for (int a = 0; a < 256; a += 2) begin
            cycle_begin(16'(a), 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            chk("reset pred m0", 32'(pt[0]), 32'd0);
            chk("reset sel m0", 32'(ps[0]), 32'd0);
            chk("reset bcnt m0", 32'(bcnt[0]), 32'd0);
            cycle_end();
        end

        // table-driven local-history sequence
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle_begin(vecs[i].if_pc, vecs[i].v, vecs[i].pc2, vecs[i].t, vecs[i].clr, 1'b1);
            chk($sformatf("vec%0d lc m2", i), 32'(lp[2]), 32'(vecs[i].e_lc));
            chk($sformatf("vec%0d pred m2", i), 32'(pt[2]), 32'(vecs[i].e_lc));
            chk($sformatf("vec%0d gl m0", i), 32'(gp[0]), 32'(vecs[i].e_gl));
            chk($sformatf("vec%0d pred m0", i), 32'(pt[0]), 32'(vecs[i].e_pred0));
            chk($sformatf("vec%0d bcnt m0", i), 32'(bcnt[0]), 32'(vecs[i].e_bc));
            cycle_end();
        end

        // static mode statistics, then clear racing an update
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle_begin(16'h1234, 1'b1, 16'h1236, 1'b1, 1'b0, 1'b1);
            chk("m3 static pred", 32'(pt[3]), 32'd0);
            cycle_end();
        end
        cycle_begin(16'h1234, 1'b1, 16'h1236, 1'b1, 1'b1, 1'b1);
        chk("m3 bcnt 5", 32'(bcnt[3]), 32'd5);
        chk("m3 mcnt 5", 32'(mcnt[3]), 32'd5);
        cycle_end();
        cycle_begin(16'h1234, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("m3 bcnt cleared", 32'(bcnt[3]), 32'd0);
        chk("m3 mcnt cleared", 32'(mcnt[3]), 32'd0);
        cycle_end();

        // choice training: A=0x4000 not-taken, B=0x4002 taken, A taken
        // -> global right via B's training, local wrong, choice[0] goes to 2
        do_reset();
        cycle_begin(16'h4000, 1'b1, 16'h4002, 1'b0, 1'b0, 1'b1); cycle_end();
        cycle_begin(16'h4000, 1'b1, 16'h4004, 1'b1, 1'b0, 1'b1); cycle_end();
        cycle_begin(16'h4000, 1'b1, 16'h4002, 1'b1, 1'b0, 1'b1);
        chk("choice sel before", 32'(ps[0]), 32'd0);
        chk("choice gl before", 32'(gp[0]), 32'd1);
        chk("choice lc before", 32'(lp[0]), 32'd0);
        cycle_end();
        cycle_begin(16'h4000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("choice sel m0 after", 32'(ps[0]), 32'd1);
        chk("choice sel m1 forced", 32'(ps[1]), 32'd1);
        chk("choice sel m2 forced", 32'(ps[2]), 32'd0);
        cycle_end();

        // reset asserted mid-update
        cycle_begin(16'h4000, 1'b1, 16'h4002, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst sel m0", 32'(ps[0]), 32'd0);
        chk("rst pred", 32'(pt), 32'd0);
        chk("rst bcnt m0", 32'(bcnt[0]), 32'd0);
        chk("rst mcnt m0", 32'(mcnt[0]), 32'd0);
        check_model();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle_begin(16'h4000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1); cycle_end();

        // randomized traffic with aliasing around 0x4000
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] b, pc;
            logic        v, t, c;
            v = ($urandom_range(0, 2) != 0);
            t = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 63) == 0);
            b = 16'h4000 + 16'(2 * $urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) b = 16'($urandom);
            pc = ($urandom_range(0, 3) == 0) ? b : 16'h4000 + 16'(2 * $urandom_range(0, 31));
            if (v) cycle_begin(pc, 1'b1, b + 16'd2, t, c, 1'b1);
            else   cycle_begin(pc, 1'b0, 16'hxxxx, 1'bx, c, 1'b1);
            cycle_end();
        end

        // counter saturation
        do_reset();
        for (int i = 0; i < 65534; i++) begin
            cycle_begin(16'($urandom), 1'b1, 16'($urandom), 1'b1, 1'b0, (i % 4096) == 0);
            cycle_end();
        end
        cycle_begin(16'h0, 1'b1, 16'h0102, 1'b1, 1'b0, 1'b1);
        chk("bcnt FFFE", 32'(bcnt[0]), 32'hFFFE);
        cycle_end();
        for (int i = 0; i < 2; i++) begin
            cycle_begin(16'h0, 1'b1, 16'h0102, 1'b1, 1'b0, 1'b1);
            cycle_end();
        end
        cycle_begin(16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("bcnt sat m0", 32'(bcnt[0]), 32'hFFFF);
        chk("bcnt sat m3", 32'(bcnt[3]), 32'hFFFF);
        chk("mcnt sat m3", 32'(mcnt[3]), 32'hFFFF);
        cycle_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tournament_br_predictor.md
Name: tournament_br_predictor

Overview:
Parametrised successor to the fixed global/local/choice predictor trio. One block holds a gshare global PHT, a two-level local predictor, the choice table and the selection logic. It also holds branch and mispredict statistic counters, which feed the counter readout path. Prediction is looked up at IF from pc_out; training happens at WB on committed branches, with the same update timing as the current predictors.

Parameters:
GHR_BITS, 8, global history length; global PHT has 2^GHR_BITS counters
LHT_LOG2, 6, log2 of the local history table entries
LHIST_BITS, 6, local history length; local PHT has 2^LHIST_BITS counters
CHOICE_LOG2, 8, log2 of the choice table entries
CTR_BITS, 2, saturating counter width for all PHT and choice entries (range 2..4)
MODE, 0, 0=tournament, 1=global only, 2=local only, 3=static not-taken

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
if_pc  input  16  fetch PC (pc_out)
wb_valid  input  1  committed branch in WB this cycle (wbisbranch)
wb_pcplus2  input  16  PC+2 of the WB branch
actual_taken  input  1  resolved direction of the WB branch
stat_clear  input  1  synchronous clear of the statistic counters
pred_taken  output  1  final prediction for if_pc
gl_pred_taken  output  1  global component prediction for if_pc
lc_pred_taken  output  1  local component prediction for if_pc
pred_select  output  1  1 = global component chosen for if_pc
branch_count  output  16  committed branches, saturating
mispredict_count  output  16  committed mispredictions, saturating

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-update:
  - PHT and choice counters go to weakly-not-taken/weakly-local, value 2^(CTR_BITS-1)-1.
  - GHR, all LHT entries, branch_count and mispredict_count go to 0.
  - Outputs after reset: pred_taken=0, gl_pred_taken=0, lc_pred_taken=0, pred_select=0.
- Fetch lookup is combinational from the registered state and has zero latency. Branch address b = if_pc.
  - Global index = GHR XOR b[GHR_BITS:1].
  - LHT index = b[LHT_LOG2:1]. Local PHT index = LHT[LHT index].
  - Choice index = b[CHOICE_LOG2:1].
  - A counter predicts taken when its MSB is 1.
  - pred_select = choice counter MSB.
- Final prediction by MODE:
  - MODE 0: pred_taken = pred_select ? gl : lc.
  - MODE 1: pred_taken = gl, and pred_select is forced to 1.
  - MODE 2: pred_taken = lc, and pred_select is forced to 0.
  - MODE 3: pred_taken = 0. Component outputs still report table state.
- Update happens on the rising edge when wb_valid=1; the block is idle when wb_valid=0.
  - Branch address b = wb_pcplus2 - 2 (16-bit wrap).
  - Indices use the same formulas as lookup, evaluated on the pre-edge state.
- PHT update: the indexed global and local counters increment on taken and decrement on not-taken. They saturate at 0 and 2^CTR_BITS-1.
- Choice update, in MODE 0 only:
  - Increment if global was correct and local was wrong.
  - Decrement if local was correct and global was wrong.
  - Otherwise hold. Saturates at both ends.
- History update:
  - GHR <= {GHR[GHR_BITS-2:0], actual_taken}.
  - Indexed LHT entry <= {entry[LHIST_BITS-2:0], actual_taken}.
  - History is non-speculative: it is updated only at WB.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update value. The new value is visible the following cycle.
- Statistics, evaluated per update cycle:
  - branch_count += 1 when wb_valid=1.
  - mispredict_count += 1 when the final prediction recomputed at WB (per MODE) differs from actual_taken.
  - Both counters hold at 16'hFFFF and do not wrap.
  - stat_clear=1 sets both to 0 on the edge and has priority over a simultaneous increment.
- X on wb_pcplus2 or actual_taken while wb_valid=0 must not corrupt any state.

Test Plan:
- Reset, then sweep if_pc over 0x0000..0x00FE -> pred_taken=0, pred_select=0, both counts 0.
- MODE=2, wb_pcplus2=0x3002, actual_taken=1 for 6 cycles -> at if_pc=0x3000, lc_pred_taken=0. After a 7th update -> lc_pred_taken=1 (local PHT[63] = 2).
- MODE=3, 5 updates with taken=1 -> pred_taken stays 0, branch_count=5, mispredict_count=5. Then stat_clear together with wb_valid -> both counts 0 on the next cycle.
- Force branch_count to 0xFFFE and apply 3 updates -> count saturates at 0xFFFF.
- Same-cycle check: if_pc=0x3000 with a WB update of 0x3002 that flips the counter MSB -> pred_taken shows the old value that cycle and the new value the next cycle.
- MODE 0, alternating taken/not-taken at 0x4000 so global is correct and local is wrong -> choice counter increments and pred_select becomes 1. Assert rst during a wb_valid update -> all state and outputs return to reset values immediately.
